riscv_alu_issue_ctrl: RTL

Issue/stall controller sitting between the decode/execute pipeline stage and the pipelined RISC-V ALU (32I/32M/32F). It accepts one ALU op at a time and loads the ALU-reported stall_cycles count. It holds the pipeline with stall_o while the multi-cycle unit (divider, multiplier, FPU) settles. It then captures the ALU result into a registered writeback slot with a valid/ready handshake, and provides flush and saturating performance counters.

---
 rtl/riscv_alu_ctrl_pkg.sv | 15 +
 rtl/riscv_alu_issue_ctrl_if.sv | 37 +++
 rtl/sat_counter.sv | 24 ++
 rtl/riscv_alu_issue_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/riscv_alu_ctrl_pkg.sv
// Shared types and default widths for the ALU issue/stall controller.
package riscv_alu_ctrl_pkg;

    localparam int unsigned CNT_W_DEF  = 5;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_W_DEF  = 5;
    localparam int unsigned PERF_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/riscv_alu_issue_ctrl_if.sv
// Pipeline-side bundle of the ALU issue controller: issue, writeback, flush and perf outputs.
interface riscv_alu_issue_ctrl_if
    import riscv_alu_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_W  = REG_W_DEF,
    parameter int unsigned PERF_W = PERF_W_DEF
);
    logic              issue_valid_i;
    logic [CNT_W-1:0]  stall_cycles_i;
    logic [REG_W-1:0]  rd_i;
    logic [DATA_W-1:0] result_i;
    logic              flush_i;
    logic              wb_ready_i;
    logic              stall_o;
    logic              busy_o;
    logic              wb_valid_o;
    logic [DATA_W-1:0] wb_data_o;
    logic [REG_W-1:0]  wb_rd_o;
    logic              proto_err_o;
    logic [PERF_W-1:0] busy_cycles_o;
    logic [PERF_W-1:0] ops_done_o;

    modport master (
        output issue_valid_i, stall_cycles_i, rd_i, result_i, flush_i, wb_ready_i,
        input  stall_o, busy_o, wb_valid_o, wb_data_o, wb_rd_o, proto_err_o,
               busy_cycles_o, ops_done_o
    );

    modport slave (
        input  issue_valid_i, stall_cycles_i, rd_i, result_i, flush_i, wb_ready_i,
        output stall_o, busy_o, wb_valid_o, wb_data_o, wb_rd_o, proto_err_o,
               busy_cycles_o, ops_done_o
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for performance events.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock_i,
    input  logic         resetn_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] r_count;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_count <= '0;
        end else if (inc_i && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/riscv_alu_issue_ctrl.sv
// Issue/stall controller between decode/execute and the multi-cycle RISC-V ALU:
// countdown of ALU stall cycles, registered writeback slot, flush and perf counters.
module riscv_alu_issue_ctrl
    import riscv_alu_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_W  = REG_W_DEF,
    parameter int unsigned PERF_W = PERF_W_DEF
) (
    input logic                  clock_i,
    input logic                  resetn_i,
    riscv_alu_issue_ctrl_if.slave bus
);

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_count;
    logic [REG_W-1:0]  r_rd_hold;
    logic [REG_W-1:0]  r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_proto_err;

    logic              w_accept;
    logic              w_multi;
    logic              w_last;
    logic              w_capture;
    logic              w_stall;
    logic              w_busy;
    logic              w_wb_valid;
    logic              w_op_done;
    logic [PERF_W-1:0] w_busy_cycles;
    logic [PERF_W-1:0] w_ops_done;

    // A new op may enter from IDLE, or from DONE when writeback drains in the same cycle.
    assign w_accept  = bus.issue_valid_i & ~bus.flush_i &
                       ((r_state == IDLE) | ((r_state == DONE) & bus.wb_ready_i));
    assign w_multi   = (bus.stall_cycles_i != '0);
    assign w_last    = (r_state == BUSY) & (r_count <= CNT_W'(1));
    assign w_capture = ~bus.flush_i & ((w_accept & ~w_multi) | w_last);
    assign w_op_done = w_wb_valid & bus.wb_ready_i & ~bus.flush_i;

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        if (bus.flush_i) begin
            w_next_state = IDLE;
        end else if (w_accept) begin
            w_next_state = w_multi ? BUSY : DONE;
        end else begin
            case (r_state)
                BUSY:    if (w_last) w_next_state = DONE;
                DONE:    if (bus.wb_ready_i) w_next_state = IDLE;
                default: w_next_state = r_state;
            endcase
        end
    end

    always_comb begin
        w_stall    = 1'b0;
        w_busy     = 1'b0;
        w_wb_valid = 1'b0;
        case (r_state)
            IDLE: w_stall = w_accept & w_multi;
            BUSY: begin
                w_stall = 1'b1;
                w_busy  = 1'b1;
            end
            DONE: begin
                w_wb_valid = 1'b1;
                w_stall    = ~bus.wb_ready_i | (w_accept & w_multi);
            end
            default: w_stall = 1'b0;
        endcase
    end

    // NOTE: the writeback slot is reset so wb_data_o/wb_rd_o read 0 before the first op.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_count     <= '0;
            r_rd_hold   <= '0;
            r_wb_data   <= '0;
            r_wb_rd     <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (bus.flush_i) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= bus.stall_cycles_i;
            end else if ((r_state == BUSY) && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end

            if (w_accept) begin
                r_rd_hold <= bus.rd_i;
            end

            // Single-cycle ops take rd_i live; multi-cycle ops use the copy held since issue.
            if (w_capture) begin
                r_wb_data <= bus.result_i;
                r_wb_rd   <= w_accept ? bus.rd_i : r_rd_hold;
            end

            if (bus.issue_valid_i && (r_state == BUSY)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    sat_counter #(.W(PERF_W)) u_busy_cnt (
        .clock_i  (clock_i),
        .resetn_i (resetn_i),
        .inc_i    (w_busy),
        .count_o  (w_busy_cycles)
    );

    sat_counter #(.W(PERF_W)) u_ops_cnt (
        .clock_i  (clock_i),
        .resetn_i (resetn_i),
        .inc_i    (w_op_done),
        .count_o  (w_ops_done)
    );

    assign bus.stall_o       = w_stall;
    assign bus.busy_o        = w_busy;
    assign bus.wb_valid_o    = w_wb_valid;
    assign bus.wb_data_o     = r_wb_data;
    assign bus.wb_rd_o       = r_wb_rd;
    assign bus.proto_err_o   = r_proto_err;
    assign bus.busy_cycles_o = w_busy_cycles;
    assign bus.ops_done_o    = w_ops_done;

endmodule
